counter_stream_checker: RTL and testbench
=========================================

Name: counter_stream_checker

Overview:
- Receive-side companion to the free-running benchmark counters.
- Samples a WIDTH-bit counter value stream, locks onto a run of +1 increments, then reports every broken increment.
- Keeps a saturating error count and raises a sticky fail flag.
- Sits on the observing side of a counter output bus, in the same clock domain as its sampling clock.

Parameters:
- WIDTH, 8, counter value width.
- LOCK_LEN, 4, consecutive good increments needed to assert locked (min 1).
- ERR_W, 8, error counter width; saturation value is all-ones.
- ALLOW_ZERO, 1, when 1 a sampled value of 0 in TRACK is accepted as a legal counter reset.

Ports:
- clk  input  1  sampling clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: return to IDLE, zero err_cnt, drop fail.
- valid  input  1  q is sampled this cycle.
- q  input  WIDTH  observed counter value.
- locked  output  1  high while in TRACK.
- err  output  1  one-cycle pulse per detected mismatch in TRACK.
- err_cnt  output  ERR_W  saturating mismatch count.
- fail  output  1  sticky; set when err_cnt saturates.
- expected  output  WIDTH  next value expected (prev+1 mod 2^WIDTH).

Behaviour:
- All outputs are registered.
- Reset values: locked=0, err=0, err_cnt=0, fail=0, expected=0, state IDLE, prev=0, run=0.
- Latency: a valid sample at edge N is reflected in the outputs after edge N.
- Internal registers: prev (WIDTH), run (clog2(LOCK_LEN+1)).
- Good increment: q == prev+1 computed mod 2^WIDTH, so prev=all-ones followed by q=0 is good.
- Every valid sample loads prev<=q and expected<=q+1, except in FAIL.
- IDLE: on valid, go to ACQ with run=0. No error is possible.
- ACQ:
  - Good sample: run++; if run+1==LOCK_LEN, go to TRACK (locked=1) and clear run.
  - Bad sample: run=0, stay in ACQ, no err and no count. A zero is just a bad sample here.
- TRACK:
  - Good sample, or ALLOW_ZERO and q==0: stay in TRACK.
  - Otherwise: err=1 for one cycle, err_cnt+1 unless saturated, go to ACQ with run=0, locked=0 the same cycle.
  - If this error makes err_cnt reach all-ones: go to FAIL instead of ACQ; fail=1.
- FAIL:
  - locked=0, fail=1.
  - valid is ignored: prev and expected hold.
  - Leave only via clr or rst.
- Cycles without valid: no state change; err stays 0.
- clr has priority over valid in the same cycle. The sample is discarded and the state becomes IDLE. prev and expected are untouched.
- rst asserted mid-stream: immediate return to reset values regardless of clk.
- err_cnt never wraps; it holds at all-ones.

Decomposition:
- Shared package: state enum (IDLE, ACQ, TRACK, FAIL) and a function next_val(x)=x+1 mod 2^WIDTH.
- Both this block and future counter benchmarks/checkers import the package.
- One natural sub-module: sat_counter (ERR_W-wide saturating incrementer with clear and a saturated flag), instantiated for err_cnt.
- The FSM stays in the top.

Test Plan:
- Lock: after rst release, valid each cycle with q=10,11,12,13,14 → locked rises after the 5th sample (1 capture + LOCK_LEN=4 good); err=0, expected=15.
- Wrap: locked stream 253,254,255,0,1 → no err, locked stays 1, expected=2.
- Mismatch: locked stream 20,21,23 → err pulses once after the 23 sample; err_cnt=1; locked drops. Then 24,25,26,27 → relock after 27.
- Zero accept: locked at 40, then q=0,1 with ALLOW_ZERO=1 → no err. Same stimulus with ALLOW_ZERO=0 → err, err_cnt=1.
- Saturation: ERR_W=2, force 3 mismatches while locked (relock each time) → err_cnt=3, fail=1. Further valid samples leave expected and err_cnt unchanged. Then clr → fail=0, err_cnt=0, state IDLE.
- Priority/reset: clr and valid in the same cycle with q=99 → IDLE, no capture. Assert rst mid-TRACK between clock edges → locked=0 and err_cnt=0 immediately.

Source files
------------

// File: rtl/counter_stream_checker_pkg.sv
// Shared definitions for the counter benchmarks and their stream checkers.
package counter_stream_checker_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    // Callers truncate the result to their own width, giving x+1 mod 2^W.
    function automatic logic [MAX_W-1:0] next_val(input logic [MAX_W-1:0] x);
        return x + MAX_W'(1);
    endfunction

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/counter_stream_checker.sv
// Locks onto a +1 counter stream, then flags and counts every broken increment.
module counter_stream_checker
    import counter_stream_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_LEN   = 4,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             valid,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail,
    output logic [WIDTH-1:0] expected
);

    localparam int unsigned      RUN_W    = $clog2(LOCK_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN);
    localparam logic [ERR_W-1:0] CNT_PRE  = ~ERR_W'(1);

    function automatic logic [WIDTH-1:0] inc_w(input logic [WIDTH-1:0] x);
        return WIDTH'(next_val(MAX_W'(x)));
    endfunction

    state_e           state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             good;
    logic             accept;
    logic             err_hit;
    logic             will_sat;
    logic             sat;

    assign run_inc  = run + RUN_W'(1);
    assign good     = (q == inc_w(prev));
    assign accept   = good || (ALLOW_ZERO && (q == '0));
    assign err_hit  = !clr && valid && (state == ST_TRACK) && !accept;
    // The mismatch that lands the count on all-ones sends the FSM to FAIL.
    assign will_sat = !sat && (err_cnt == CNT_PRE);

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_hit),
        .cnt (err_cnt),
        .sat (sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            prev     <= '0;
            expected <= '0;
            run      <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            fail     <= 1'b0;
        end else if (clr) begin
            // The sample is dropped; prev and expected keep their values.
            state  <= ST_IDLE;
            run    <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
            fail   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (valid) begin
                if (state != ST_FAIL) begin
                    prev     <= q;
                    expected <= inc_w(q);
                end
                case (state)
                    ST_IDLE: begin
                        state <= ST_ACQ;
                        run   <= '0;
                    end
                    ST_ACQ: begin
                        if (good) begin
                            if (run_inc == RUN_LOCK) begin
                                state  <= ST_TRACK;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ST_TRACK: begin
                        if (!accept) begin
                            err    <= 1'b1;
                            run    <= '0;
                            locked <= 1'b0;
                            if (will_sat) begin
                                state <= ST_FAIL;
                                fail  <= 1'b1;
                            end else begin
                                state <= ST_ACQ;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_stream_checker.sv
// Scoreboard bench: three checker configs share one stimulus stream.
module tb_counter_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       valid;
    logic [7:0] q;

    logic       lk0, er0, fl0;
    logic [7:0] cnt0, x0;
    logic       lk1, er1, fl1;
    logic [7:0] cnt1, x1;
    logic       lk2, er2, fl2;
    logic [1:0] cnt2;
    logic [7:0] x2;

    always #5 clk = ~clk;

    counter_stream_checker dut0 (
        .clk(clk), .rst(rst_n), .clr(clr), .valid(valid), .q(q),
        .locked(lk0), .err(er0), .err_cnt(cnt0), .fail(fl0), .expected(x0)
    );

    counter_stream_checker #(.ALLOW_ZERO(1'b0)) dut1 (
        .clk(clk), .rst(rst_n), .clr(clr), .valid(valid), .q(q),
        .locked(lk1), .err(er1), .err_cnt(cnt1), .fail(fl1), .expected(x1)
    );

    counter_stream_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst_n), .clr(clr), .valid(valid), .q(q),
        .locked(lk2), .err(er2), .err_cnt(cnt2), .fail(fl2), .expected(x2)
    );

    typedef struct {
        int         dut;
        int         idx;
        logic       l;
        logic       e;
        logic [7:0] c;
        logic       f;
        logic [7:0] x;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq   = 0;

    function automatic void chk(string nm, int idx, logic [7:0] act, logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, required %0d", nm, idx, act, req);
        end
    endfunction

    // Monitor: every driven cycle leaves one entry, checked just after the edge.
    always @(posedge clk) begin
        exp_t       e;
        logic       a_l, a_e, a_f;
        logic [7:0] a_c, a_x;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0: begin a_l = lk0; a_e = er0; a_c = cnt0; a_f = fl0; a_x = x0; end
                1: begin a_l = lk1; a_e = er1; a_c = cnt1; a_f = fl1; a_x = x1; end
                default: begin a_l = lk2; a_e = er2; a_c = {6'b0, cnt2}; a_f = fl2; a_x = x2; end
            endcase
            chk($sformatf("dut%0d.locked", e.dut),   e.idx, {7'b0, a_l}, {7'b0, e.l});
            chk($sformatf("dut%0d.err", e.dut),      e.idx, {7'b0, a_e}, {7'b0, e.e});
            chk($sformatf("dut%0d.err_cnt", e.dut),  e.idx, a_c, e.c);
            chk($sformatf("dut%0d.fail", e.dut),     e.idx, {7'b0, a_f}, {7'b0, e.f});
            chk($sformatf("dut%0d.expected", e.dut), e.idx, a_x, e.x);
        end
    end

    task automatic step(input int d, input logic v, input logic [7:0] qq, input logic c,
                        input logic el, input logic ee, input logic [7:0] ec,
                        input logic ef, input logic [7:0] ex);
        exp_t e;
        @(negedge clk);
        valid = v;
        q     = qq;
        clr   = c;
        e.dut = d; e.idx = seq; e.l = el; e.e = ee; e.c = ec; e.f = ef; e.x = ex;
        seq++;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic smp(input int d, input logic [7:0] qq, input logic el, input logic ee,
                       input logic [7:0] ec, input logic ef, input logic [7:0] ex);
        step(d, 1'b1, qq, 1'b0, el, ee, ec, ef, ex);
    endtask

    task automatic clear(input int d, input logic [7:0] ex);
        step(d, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, ex);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        q     = 8'd0;
        #12;
        chk("rst.dut0.locked", 0, {7'b0, lk0}, 8'd0);
        chk("rst.dut0.err", 0, {7'b0, er0}, 8'd0);
        chk("rst.dut0.err_cnt", 0, cnt0, 8'd0);
        chk("rst.dut0.fail", 0, {7'b0, fl0}, 8'd0);
        chk("rst.dut0.expected", 0, x0, 8'd0);
        chk("rst.dut1.err_cnt", 0, cnt1, 8'd0);
        chk("rst.dut2.err_cnt", 0, {6'b0, cnt2}, 8'd0);
        chk("rst.dut2.fail", 0, {7'b0, fl2}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock: one capture plus four good increments
        smp(0, 8'd10, 0, 0, 0, 0, 8'd11);
        smp(0, 8'd11, 0, 0, 0, 0, 8'd12);
        smp(0, 8'd12, 0, 0, 0, 0, 8'd13);
        smp(0, 8'd13, 0, 0, 0, 0, 8'd14);
        smp(0, 8'd14, 1, 0, 0, 0, 8'd15);
        step(0, 1'b0, 8'd77, 1'b0, 1, 0, 0, 0, 8'd15);

        // Wrap through 255 -> 0
        clear(0, 8'd15);
        smp(0, 8'd250, 0, 0, 0, 0, 8'd251);
        smp(0, 8'd251, 0, 0, 0, 0, 8'd252);
        smp(0, 8'd252, 0, 0, 0, 0, 8'd253);
        smp(0, 8'd253, 0, 0, 0, 0, 8'd254);
        smp(0, 8'd254, 1, 0, 0, 0, 8'd255);
        smp(0, 8'd255, 1, 0, 0, 0, 8'd0);
        smp(0, 8'd0,   1, 0, 0, 0, 8'd1);
        smp(0, 8'd1,   1, 0, 0, 0, 8'd2);

        // Mismatch and relock
        clear(0, 8'd2);
        smp(0, 8'd17, 0, 0, 0, 0, 8'd18);
        smp(0, 8'd18, 0, 0, 0, 0, 8'd19);
        smp(0, 8'd19, 0, 0, 0, 0, 8'd20);
        smp(0, 8'd20, 0, 0, 0, 0, 8'd21);
        smp(0, 8'd21, 1, 0, 0, 0, 8'd22);
        smp(0, 8'd23, 0, 1, 1, 0, 8'd24);
        smp(0, 8'd24, 0, 0, 1, 0, 8'd25);
        smp(0, 8'd25, 0, 0, 1, 0, 8'd26);
        smp(0, 8'd26, 0, 0, 1, 0, 8'd27);
        smp(0, 8'd27, 1, 0, 1, 0, 8'd28);

        // Zero accepted with ALLOW_ZERO=1
        clear(0, 8'd28);
        smp(0, 8'd36, 0, 0, 0, 0, 8'd37);
        smp(0, 8'd37, 0, 0, 0, 0, 8'd38);
        smp(0, 8'd38, 0, 0, 0, 0, 8'd39);
        smp(0, 8'd39, 0, 0, 0, 0, 8'd40);
        smp(0, 8'd40, 1, 0, 0, 0, 8'd41);
        smp(0, 8'd0,  1, 0, 0, 0, 8'd1);
        smp(0, 8'd1,  1, 0, 0, 0, 8'd2);

        // Same stimulus, ALLOW_ZERO=0
        clear(1, 8'd2);
        smp(1, 8'd36, 0, 0, 0, 0, 8'd37);
        smp(1, 8'd37, 0, 0, 0, 0, 8'd38);
        smp(1, 8'd38, 0, 0, 0, 0, 8'd39);
        smp(1, 8'd39, 0, 0, 0, 0, 8'd40);
        smp(1, 8'd40, 1, 0, 0, 0, 8'd41);
        smp(1, 8'd0,  0, 1, 1, 0, 8'd1);
        smp(1, 8'd1,  0, 0, 1, 0, 8'd2);

        // Saturation with ERR_W=2
        clear(2, 8'd2);
        smp(2, 8'd100, 0, 0, 0, 0, 8'd101);
        smp(2, 8'd101, 0, 0, 0, 0, 8'd102);
        smp(2, 8'd102, 0, 0, 0, 0, 8'd103);
        smp(2, 8'd103, 0, 0, 0, 0, 8'd104);
        smp(2, 8'd104, 1, 0, 0, 0, 8'd105);
        smp(2, 8'd110, 0, 1, 1, 0, 8'd111);
        smp(2, 8'd111, 0, 0, 1, 0, 8'd112);
        smp(2, 8'd112, 0, 0, 1, 0, 8'd113);
        smp(2, 8'd113, 0, 0, 1, 0, 8'd114);
        smp(2, 8'd114, 1, 0, 1, 0, 8'd115);
        smp(2, 8'd120, 0, 1, 2, 0, 8'd121);
        smp(2, 8'd121, 0, 0, 2, 0, 8'd122);
        smp(2, 8'd122, 0, 0, 2, 0, 8'd123);
        smp(2, 8'd123, 0, 0, 2, 0, 8'd124);
        smp(2, 8'd124, 1, 0, 2, 0, 8'd125);
        smp(2, 8'd130, 0, 1, 3, 1, 8'd131);
        smp(2, 8'd131, 0, 0, 3, 1, 8'd131);
        smp(2, 8'd200, 0, 0, 3, 1, 8'd131);
        clear(2, 8'd131);
        smp(2, 8'd50, 0, 0, 0, 0, 8'd51);
        smp(2, 8'd51, 0, 0, 0, 0, 8'd52);

        // clr beats valid; 99 must not be captured
        clear(0, 8'd52);
        smp(0, 8'd60, 0, 0, 0, 0, 8'd61);
        smp(0, 8'd61, 0, 0, 0, 0, 8'd62);
        smp(0, 8'd62, 0, 0, 0, 0, 8'd63);
        smp(0, 8'd63, 0, 0, 0, 0, 8'd64);
        smp(0, 8'd64, 1, 0, 0, 0, 8'd65);
        step(0, 1'b1, 8'd99, 1'b1, 0, 0, 0, 0, 8'd65);
        smp(0, 8'd100, 0, 0, 0, 0, 8'd101);
        smp(0, 8'd101, 0, 0, 0, 0, 8'd102);
        smp(0, 8'd102, 0, 0, 0, 0, 8'd103);
        smp(0, 8'd103, 0, 0, 0, 0, 8'd104);
        smp(0, 8'd104, 1, 0, 0, 0, 8'd105);
        smp(0, 8'd110, 0, 1, 1, 0, 8'd111);
        smp(0, 8'd111, 0, 0, 1, 0, 8'd112);
        smp(0, 8'd112, 0, 0, 1, 0, 8'd113);
        smp(0, 8'd113, 0, 0, 1, 0, 8'd114);
        smp(0, 8'd114, 1, 0, 1, 0, 8'd115);

        // Asynchronous reset in the middle of TRACK
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.locked", seq, {7'b0, lk0}, 8'd0);
        chk("async_rst.err_cnt", seq, cnt0, 8'd0);
        chk("async_rst.expected", seq, x0, 8'd0);
        chk("async_rst.fail", seq, {7'b0, fl0}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        smp(0, 8'd5, 0, 0, 0, 0, 8'd6);

        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
